fifo_buffer: RTL and testbench
==============================

Name: fifo_buffer

Overview:
- Synchronous single-clock FIFO: 16 entries × 8 bits.
- Sits between a byte producer (WR/dataIn) and a byte consumer (RD/dataOut).
- Flags FULL and EMPTY so upstream and downstream logic can throttle.
- Registered read data; occupancy tracked by an internal counter.

Parameters:
- DATA_W, 8, width of dataIn, dataOut and each storage word.
- DEPTH, 16, number of storage entries; must be a power of two.
- ADDR_W, 4, pointer width; equals log2(DEPTH).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
- dataIn  input  DATA_W  write data, sampled on the rising Clk edge when a write is accepted.
- WR  input  1  write request, level-sensitive; one word per cycle while high.
- RD  input  1  read request, level-sensitive; one word per cycle while high.
- dataOut  output  DATA_W  registered read data.
- FULL  output  1  high when occupancy == DEPTH.
- EMPTY  output  1  high when occupancy == 0.

Behaviour:
- State:
  - Storage array: DEPTH × DATA_W.
  - Write pointer wr_ptr and read pointer rd_ptr: ADDR_W bits each.
  - Occupancy counter count: ADDR_W+1 bits, range 0..DEPTH.
  - dataOut register.
- Reset (Rst = 0, asynchronous, takes effect immediately):
  - wr_ptr = 0, rd_ptr = 0, count = 0, dataOut = 0.
  - Outputs therefore EMPTY = 1, FULL = 0.
  - Storage contents are not cleared.
  - Reset overrides any RD/WR in progress. All queued data is discarded.
- Flags: FULL and EMPTY are decoded combinationally from the registered count. They are glitch-free relative to Clk and valid from the edge that changes count.
- Write accept: wr_en = WR & (~FULL | RD_accepted).
  - On the rising edge: mem[wr_ptr] <= dataIn, and wr_ptr increments modulo DEPTH.
- Read accept: rd_en = RD & ~EMPTY.
  - On the rising edge: dataOut <= mem[rd_ptr], and rd_ptr increments modulo DEPTH.
  - Read latency: data is visible on dataOut one edge after RD is sampled high.
  - When no read is accepted, dataOut holds its previous value.
- Overflow: WR while FULL, with no accepted read in the same cycle, is ignored. Pointer, count and memory are unchanged and no error flag is raised.
- Underflow: RD while EMPTY is ignored. dataOut holds, rd_ptr and count are unchanged.
- Simultaneous RD & WR:
  - Not empty: both accepted; count unchanged.
  - Full: the read frees a slot, so the write is also accepted; FULL stays 1.
  - Empty: only the write is accepted (no read-through bypass). EMPTY deasserts next cycle and the word is readable from the following cycle.
- Count update:
  - +1 on write-only.
  - −1 on read-only.
  - Unchanged on both or neither.
- Wrap-around: pointers roll from DEPTH−1 to 0 naturally. Ordering is strictly first-in, first-out across the wrap.
- No combinational path from inputs to dataOut.

Test Plan:
- Assert Rst = 0 for one cycle, then release -> EMPTY = 1, FULL = 0, dataOut = 0x00. Assert RD for 2 cycles -> dataOut stays 0x00, EMPTY stays 1.
- Hold WR = 1 and present dataIn = 0..17, one value per cycle.
  - FULL rises on the edge that writes 15 (16th word). EMPTY falls after the first write.
  - Values 16 and 17 are dropped.
- Then WR = 0, RD = 1 for 18 cycles.
  - dataOut = 0x00, 0x01 … 0x0F on successive edges.
  - FULL drops after the first read; EMPTY rises after the 16th read.
  - dataOut holds 0x0F for the remaining 2 cycles.
- Wrap-around: write 10 words (0xA0..0xA9) and read all 10. Then write 16 words (0xB0..0xBF) -> FULL = 1. Read all 16 -> 0xB0..0xBF returned in order.
- Simultaneous RD & WR:
  - At full (16 entries): RD = WR = 1 with dataIn = 0xCC for 1 cycle -> the oldest word is output, FULL stays 1, and 0xCC is read last after a full drain.
  - At empty: RD = WR = 1 with dataIn = 0x55 -> dataOut unchanged, next cycle EMPTY = 0. A subsequent read returns 0x55.
- Reset mid-operation: with 5 entries queued, pulse Rst = 0 asynchronously between edges -> immediately EMPTY = 1, FULL = 0, dataOut = 0x00. The next write/read pair returns the newly written value, not stale data.

Source files
------------

// File: rtl/fifo_buffer_if.sv
// Byte-stream handshake between producer/consumer logic and the FIFO.
// The master side drives requests and write data; the slave side is the FIFO.
interface fifo_buffer_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] dataIn;
    logic              WR;
    logic              RD;
    logic [DATA_W-1:0] dataOut;
    logic              FULL;
    logic              EMPTY;

    modport master (
        output dataIn,
        output WR,
        output RD,
        input  dataOut,
        input  FULL,
        input  EMPTY
    );

    modport slave (
        input  dataIn,
        input  WR,
        input  RD,
        output dataOut,
        output FULL,
        output EMPTY
    );
endinterface

// File: rtl/fifo_buffer.sv
// Single-clock FIFO with registered read data and a count-based FULL/EMPTY.
// A read frees a slot in the same cycle, so a write at FULL is accepted alongside a read.
module fifo_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    fifo_buffer_if.slave  bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] data_q;

    logic full_c;
    logic empty_c;
    logic rd_en;
    logic wr_en;

    // Flags decoded from the registered count only
    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == CNT_W'(0));

    assign rd_en = bus.RD & ~empty_c;
    assign wr_en = bus.WR & (~full_c | rd_en);

    assign bus.dataOut = data_q;
    assign bus.FULL    = full_c;
    assign bus.EMPTY   = empty_c;

    // Storage is intentionally not reset
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.dataIn;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            data_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                data_q <= mem[rd_ptr];
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_buffer.sv
// Directed bench for fifo_buffer: a queue of accepted writes is popped on each
// accepted read to form the expected dataOut, and the flags follow its size.
module tb_fifo_buffer;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;

    logic Clk;
    logic Rst;

    fifo_buffer_if #(.DATA_W(DATA_W)) bus ();

    fifo_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (4)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int unsigned       n_assert;
    int unsigned       n_fail;
    logic [DATA_W-1:0] sb_q [$];
    logic [DATA_W-1:0] exp_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dataOut"}, 32'(bus.dataOut), 32'(exp_dout));
        check({tag, ".EMPTY"},   32'(bus.EMPTY),   32'(sb_q.size() == 0));
        check({tag, ".FULL"},    32'(bus.FULL),    32'(sb_q.size() == DEPTH));
    endtask

    // One clock of stimulus; the reference queue is updated from pre-edge occupancy
    task automatic step(input logic wr, input logic rd, input logic [DATA_W-1:0] din, input string tag);
        logic rd_acc;
        logic wr_acc;
        @(negedge Clk);
        bus.WR     = wr;
        bus.RD     = rd;
        bus.dataIn = din;
        rd_acc = rd && (sb_q.size() != 0);
        wr_acc = wr && ((sb_q.size() < DEPTH) || rd_acc);
        if (rd_acc) exp_dout = sb_q.pop_front();
        if (wr_acc) sb_q.push_back(din);
        @(posedge Clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        exp_dout    = '0;
        Rst         = 1'b0;
        bus.WR      = 1'b0;
        bus.RD      = 1'b0;
        bus.dataIn  = '0;

        @(negedge Clk);
        @(negedge Clk);
        check_all("reset");
        Rst = 1'b1;

        // Underflow: reads on empty are ignored
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 8'h00, "underflow");

        // Fill past full; 16 and 17 are dropped
        for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 8'(i), "fill");
        check("fill.full_explicit", 32'(bus.FULL), 32'd1);

        // Drain past empty; dataOut holds 0x0F
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 8'h00, "drain");
        check("drain.hold_explicit", 32'(bus.dataOut), 32'h0F);

        // Wrap-around ordering
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), "wrap_a_wr");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, "wrap_a_rd");
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'hB0 + i), "wrap_b_wr");
        check("wrap_b.full_explicit", 32'(bus.FULL), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, "wrap_b_rd");
        check("wrap_b.last_explicit", 32'(bus.dataOut), 32'hBF);

        // Simultaneous read and write at full
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i), "full_fill");
        step(1'b1, 1'b1, 8'hCC, "full_rw");
        check("full_rw.oldest_explicit", 32'(bus.dataOut), 32'h10);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, "full_drain");
        check("full_drain.cc_last_explicit", 32'(bus.dataOut), 32'hCC);

        // Simultaneous read and write at empty: no bypass
        step(1'b1, 1'b1, 8'h55, "empty_rw");
        check("empty_rw.no_bypass_explicit", 32'(bus.dataOut), 32'hCC);
        step(1'b0, 1'b1, 8'h00, "empty_rw_rd");
        check("empty_rw_rd.value_explicit", 32'(bus.dataOut), 32'h55);

        // Asynchronous reset with entries queued
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hD0 + i), "pre_rst");
        @(negedge Clk);
        bus.WR = 1'b0;
        bus.RD = 1'b0;
        #2 Rst = 1'b0;
        sb_q.delete();
        exp_dout = '0;
        #1;
        check_all("async_rst");
        @(negedge Clk);
        Rst = 1'b1;
        step(1'b1, 1'b0, 8'h77, "post_rst_wr");
        step(1'b0, 1'b1, 8'h00, "post_rst_rd");
        check("post_rst.value_explicit", 32'(bus.dataOut), 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
